// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared lamp codes, phase/error/state types for the traffic light bus
package traffic_pkg;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;

    typedef enum logic [2:0] {
        PH_NG = 3'd0,
        PH_NY = 3'd1,
        PH_EG = 3'd2,
        PH_EY = 3'd3,
        PH_SG = 3'd4,
        PH_SY = 3'd5,
        PH_WG = 3'd6,
        PH_WY = 3'd7
    } phase_t;

    typedef enum logic [2:0] {
        ERR_NONE        = 3'd0,
        ERR_CONFLICT    = 3'd1,
        ERR_ENCODING    = 3'd2,
        ERR_SEQ         = 3'd3,
        ERR_DWELL_SHORT = 3'd4,
        ERR_DWELL_LONG  = 3'd5
    } err_code_t;

    typedef enum logic [1:0] {
        ST_ACQUIRE = 2'd0,
        ST_TRACK   = 2'd1,
        ST_FAULT   = 2'd2
    } mon_state_t;

endpackage

// File: rtl/traffic_light_monitor_if.sv
// rtl/traffic_light_monitor_if.sv - lamp bus plus monitor status bundle
interface traffic_light_monitor_if
    import traffic_pkg::*;
#(
    parameter int ROT_W = 8
);
    logic [2:0]       north;
    logic [2:0]       east;
    logic [2:0]       south;
    logic [2:0]       west;
    logic             clr_err;
    logic             locked;
    phase_t           phase;
    logic             err;
    err_code_t        err_code;
    logic [ROT_W-1:0] rotations;

    modport master (
        output north, east, south, west, clr_err,
        input  locked, phase, err, err_code, rotations
    );

    modport slave (
        input  north, east, south, west, clr_err,
        output locked, phase, err, err_code, rotations
    );
endinterface

// File: rtl/traffic_light_monitor_decoder.sv
// rtl/traffic_light_monitor_decoder.sv - combinational lamp pattern to phase classifier
module light_pattern_decoder
    import traffic_pkg::*;
(
    input  logic [2:0] north,
    input  logic [2:0] east,
    input  logic [2:0] south,
    input  logic [2:0] west,
    output logic       legal,
    output phase_t     phase,
    output logic       conflict,
    output logic       encoding_err
);
    logic [2:0] lamp [4];
    logic [2:0] n_lit;
    logic       bad_code;

    assign lamp[0] = north;
    assign lamp[1] = east;
    assign lamp[2] = south;
    assign lamp[3] = west;

    always_comb begin
        n_lit    = 3'd0;
        bad_code = 1'b0;
        phase    = PH_NG;
        // a malformed lamp is not counted as lit, so it can only surface as ENCODING
        for (int d = 0; d < 4; d++) begin
            if (lamp[d] == GREEN || lamp[d] == YELLOW) begin
                n_lit = n_lit + 3'd1;
                phase = phase_t'({d[1:0], lamp[d] == YELLOW});
            end else if (lamp[d] != RED) begin
                bad_code = 1'b1;
            end
        end
        conflict     = n_lit >= 3'd2;
        encoding_err = !conflict && (bad_code || n_lit == 3'd0);
        legal        = !conflict && !encoding_err;
    end
endmodule

// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - rotation/dwell tracker with sticky fault capture
module traffic_light_monitor
    import traffic_pkg::*;
#(
    parameter int DWELL = 1,
    parameter int ROT_W = 8
)(
    input  logic                    clk,
    input  logic                    rst_n,
    traffic_light_monitor_if.slave  bus
);
    localparam logic [7:0] DWELL_CNT = 8'(DWELL);

    logic       legal;
    logic       conflict;
    logic       encoding_err;
    phase_t     dec_phase;

    mon_state_t       state;
    phase_t           phase_q;
    logic [7:0]       dwell_cnt;
    err_code_t        code_q;
    logic [ROT_W-1:0] rot_q;
    err_code_t        viol;
    phase_t           next_phase;
    logic             at_dwell;

    light_pattern_decoder u_decoder (
        .north        (bus.north),
        .east         (bus.east),
        .south        (bus.south),
        .west         (bus.west),
        .legal        (legal),
        .phase        (dec_phase),
        .conflict     (conflict),
        .encoding_err (encoding_err)
    );

    assign next_phase = phase_t'(phase_q + 3'd1);
    assign at_dwell   = dwell_cnt == DWELL_CNT;

    // branches are mutually exclusive in priority order; only meaningful while tracking
    always_comb begin
        viol = ERR_NONE;
        if (conflict) begin
            viol = ERR_CONFLICT;
        end else if (encoding_err) begin
            viol = ERR_ENCODING;
        end else if (dec_phase == phase_q) begin
            if (at_dwell) viol = ERR_DWELL_LONG;
        end else if (dec_phase == next_phase) begin
            if (!at_dwell) viol = ERR_DWELL_SHORT;
        end else begin
            viol = ERR_SEQ;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_ACQUIRE;
            phase_q   <= PH_NG;
            dwell_cnt <= 8'd0;
            code_q    <= ERR_NONE;
            rot_q     <= '0;
        end else begin
            case (state)
                ST_ACQUIRE: begin
                    if (legal && dec_phase == PH_NG) begin
                        state     <= ST_TRACK;
                        phase_q   <= PH_NG;
                        dwell_cnt <= 8'd1;
                    end
                end
                ST_TRACK: begin
                    if (viol != ERR_NONE) begin
                        state  <= ST_FAULT;
                        code_q <= viol;
                    end else if (dec_phase == phase_q) begin
                        dwell_cnt <= dwell_cnt + 8'd1;
                    end else begin
                        phase_q   <= dec_phase;
                        dwell_cnt <= 8'd1;
                        if (phase_q == PH_WY) rot_q <= rot_q + ROT_W'(1);
                    end
                end
                ST_FAULT: begin
                    if (bus.clr_err) begin
                        state     <= ST_ACQUIRE;
                        code_q    <= ERR_NONE;
                        dwell_cnt <= 8'd0;
                    end
                end
                default: state <= ST_ACQUIRE;
            endcase
        end
    end

    assign bus.locked    = state == ST_TRACK;
    assign bus.err       = state == ST_FAULT;
    assign bus.phase     = phase_q;
    assign bus.err_code  = code_q;
    assign bus.rotations = rot_q;
endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb/tb_traffic_light_monitor.sv - randomized and directed bench against a behavioural monitor model
module tb_traffic_light_monitor;

    localparam logic [2:0] L_R = 3'b100;
    localparam logic [2:0] L_Y = 3'b010;
    localparam logic [2:0] L_G = 3'b001;

    typedef struct {
        bit fault;
        bit lock;
        int ph;
        int cnt;
        int code;
        int rot;
    } mdl_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] lamps [2][4];
    logic       clr [2];
    bit         run = 1'b0;
    int         n_checks = 0;
    int         n_pass = 0;
    mdl_t       m [2];
    int         dwell_of [2] = '{1, 3};
    int         rmod_of  [2] = '{8, 16};

    traffic_light_monitor_if #(.ROT_W(3)) bus1 ();
    traffic_light_monitor_if #(.ROT_W(4)) bus3 ();

    assign bus1.north = lamps[0][0];
    assign bus1.east  = lamps[0][1];
    assign bus1.south = lamps[0][2];
    assign bus1.west  = lamps[0][3];
    assign bus1.clr_err = clr[0];
    assign bus3.north = lamps[1][0];
    assign bus3.east  = lamps[1][1];
    assign bus3.south = lamps[1][2];
    assign bus3.west  = lamps[1][3];
    assign bus3.clr_err = clr[1];

    traffic_light_monitor #(.DWELL(1), .ROT_W(3)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    traffic_light_monitor #(.DWELL(3), .ROT_W(4)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    always #5 clk = ~clk;

    task automatic chk(string name, int act, int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic mdl_t step(mdl_t s, bit rst, bit clr_in, logic [2:0] l0, logic [2:0] l1,
                                  logic [2:0] l2, logic [2:0] l3, int dw, int rm);
        logic [2:0] l [4];
        int lit, p, v;
        bit bad;
        mdl_t r = s;
        if (!rst) begin
            r.fault = 0; r.lock = 0; r.ph = 0; r.cnt = 0; r.code = 0; r.rot = 0;
            return r;
        end
        l[0] = l0; l[1] = l1; l[2] = l2; l[3] = l3;
        lit = 0; bad = 0; p = -1;
        for (int d = 0; d < 4; d++) begin
            if (l[d] == L_G || l[d] == L_Y) begin
                lit++;
                p = 2 * d + ((l[d] == L_Y) ? 1 : 0);
            end else if (l[d] != L_R) begin
                bad = 1;
            end
        end
        v = (lit > 1) ? 1 : ((bad || lit == 0) ? 2 : 0);
        if (s.fault) begin
            if (clr_in) begin r.fault = 0; r.code = 0; r.cnt = 0; end
            return r;
        end
        if (!s.lock) begin
            if (v == 0 && p == 0) begin r.lock = 1; r.ph = 0; r.cnt = 1; end
            return r;
        end
        if (v == 0) begin
            if (p == s.ph) v = (s.cnt >= dw) ? 5 : 0;
            else if (p == (s.ph + 1) % 8) v = (s.cnt < dw) ? 4 : 0;
            else v = 3;
        end
        if (v != 0) begin
            r.fault = 1; r.lock = 0; r.code = v;
        end else if (p == s.ph) begin
            r.cnt = s.cnt + 1;
        end else begin
            if (s.ph == 7) r.rot = (s.rot + 1) % rm;
            r.ph = p; r.cnt = 1;
        end
        return r;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++)
            m[k] = step(m[k], rst_n, clr[k], lamps[k][0], lamps[k][1], lamps[k][2], lamps[k][3],
                        dwell_of[k], rmod_of[k]);
    end

    always @(negedge clk) begin
        if (run) begin
            chk("u1_locked", int'(bus1.locked), int'(m[0].lock));
            chk("u1_phase", int'(bus1.phase), m[0].ph);
            chk("u1_err", int'(bus1.err), int'(m[0].fault));
            chk("u1_err_code", int'(bus1.err_code), m[0].code);
            chk("u1_rotations", int'(bus1.rotations), m[0].rot);
            chk("u3_locked", int'(bus3.locked), int'(m[1].lock));
            chk("u3_phase", int'(bus3.phase), m[1].ph);
            chk("u3_err", int'(bus3.err), int'(m[1].fault));
            chk("u3_err_code", int'(bus3.err_code), m[1].code);
            chk("u3_rotations", int'(bus3.rotations), m[1].rot);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(int k, logic [2:0] n, logic [2:0] e, logic [2:0] s, logic [2:0] w);
        lamps[k][0] = n; lamps[k][1] = e; lamps[k][2] = s; lamps[k][3] = w;
    endtask

    task automatic put_ph(int k, int p);
        for (int d = 0; d < 4; d++)
            lamps[k][d] = (p / 2 != d) ? L_R : ((p % 2 != 0) ? L_Y : L_G);
    endtask

    task automatic pulse_clr(int k);
        clr[k] = 1'b1;
        put(k, L_R, L_R, L_R, L_R);
        tick();
        clr[k] = 1'b0;
    endtask

    int gp [2];
    int gc [2];
    bit noisy;

    initial begin
        rst_n = 1'b0;
        clr[0] = 1'b0; clr[1] = 1'b0;
        put(0, L_R, L_R, L_R, L_R);
        put(1, L_R, L_R, L_R, L_R);
        tick(); tick();
        run = 1'b1;
        chk("rst_locked", int'(bus1.locked), 0);
        chk("rst_err", int'(bus1.err), 0);
        chk("rst_phase", int'(bus1.phase), 0);
        chk("rst_rotations", int'(bus1.rotations), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            put_ph(0, i % 8);
            tick();
            if (i == 0) chk("lock_after_first_ng", int'(bus1.locked), 1);
        end
        chk("conform_rotations", int'(bus1.rotations), 2);
        chk("conform_phase", int'(bus1.phase), 3);
        chk("conform_err", int'(bus1.err), 0);

        put(0, L_G, L_G, L_R, L_R);
        tick();
        chk("conflict_err", int'(bus1.err), 1);
        chk("conflict_code", int'(bus1.err_code), 1);
        chk("conflict_locked", int'(bus1.locked), 0);
        chk("conflict_phase_hold", int'(bus1.phase), 3);
        put(0, L_R, L_R, L_R, 3'b011);
        tick();
        chk("fault_code_sticky", int'(bus1.err_code), 1);

        rst_n = 1'b0; clr[0] = 1'b1;
        tick();
        rst_n = 1'b1; clr[0] = 1'b0;
        chk("rst_in_fault_err", int'(bus1.err), 0);
        chk("rst_in_fault_code", int'(bus1.err_code), 0);
        chk("rst_in_fault_rot", int'(bus1.rotations), 0);

        for (int i = 0; i < 7; i++) begin put_ph(0, i); tick(); end
        put(0, L_R, L_R, L_R, 3'b011);
        tick();
        chk("encoding_code", int'(bus1.err_code), 2);
        clr[0] = 1'b1;
        put(0, L_G, L_G, L_R, L_R);
        tick();
        clr[0] = 1'b0;
        chk("clr_beats_viol_err", int'(bus1.err), 0);
        put_ph(0, 3); tick();
        chk("acquire_ignores", int'(bus1.locked), 0);
        put_ph(0, 0); tick();
        chk("relock_on_ng", int'(bus1.locked), 1);

        put_ph(0, 1); tick();
        put_ph(0, 2); tick();
        put_ph(0, 4); tick();
        chk("seq_code", int'(bus1.err_code), 3);
        pulse_clr(0);

        put_ph(1, 0); tick(); tick();
        put_ph(1, 1); tick();
        chk("dwell_short_code", int'(bus3.err_code), 4);
        pulse_clr(1);
        put_ph(1, 0);
        tick(); tick(); tick();
        chk("dwell3_locked", int'(bus3.locked), 1);
        tick();
        chk("dwell_long_code", int'(bus3.err_code), 5);
        pulse_clr(1);
        for (int i = 0; i < 7; i++) begin put_ph(1, i / 3); tick(); end
        chk("dwell_exact_locked", int'(bus3.locked), 1);
        chk("dwell_exact_phase", int'(bus3.phase), 2);

        gp[0] = 0; gp[1] = 0; gc[0] = 0; gc[1] = 0;
        for (int e = 0; e < 6; e++) begin
            noisy = (e % 2) == 0;
            for (int c = 0; c < 500; c++) begin
                rst_n = !(noisy && ($urandom % 200) == 0);
                for (int k = 0; k < 2; k++) begin
                    clr[k] = noisy ? (($urandom % 20) == 0) : (c == 0);
                    if (!noisy || ($urandom % 100) >= 4) begin
                        put_ph(k, gp[k]);
                        gc[k]++;
                        if (gc[k] >= dwell_of[k]) begin gc[k] = 0; gp[k] = (gp[k] + 1) % 8; end
                    end else begin
                        case ($urandom % 4)
                            0: put(k, 3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
                            1: put(k, L_G, L_R, L_Y, L_R);
                            2: put_ph(k, int'($urandom % 8));
                            default: put_ph(k, gp[k]);
                        endcase
                    end
                end
                tick();
            end
        end
        rst_n = 1'b1;
        clr[0] = 1'b0; clr[1] = 1'b0;
        tick();
        run = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

Receive-side checker for the four-way traffic light bus. It samples the North/East/South/West 3-bit lamp codes and decodes them into a phase number. It tracks the mandatory eight-phase rotation (N-G, N-Y, E-G, E-Y, S-G, S-Y, W-G, W-Y) and flags any safety or sequencing violation with a sticky error and cause code. It sits beside the light controller in the intersection subsystem and is also instantiated in benches as a protocol monitor.

## Interface

Parameters:

- DWELL, default 1: exact number of consecutive cycles each phase must be held; legal range 1..255.
- ROT_W, default 8: width of the completed-rotation counter.

Ports:

- clk  input  1: single clock; all logic on posedge.
- rst_n  input  1: reset, synchronous, active-low.
- north  input  3: lamp code; RED=100, YELLOW=010, GREEN=001.
- east  input  3: lamp code, same encoding.
- south  input  3: lamp code, same encoding.
- west  input  3: lamp code, same encoding.
- clr_err  input  1: single-cycle pulse; leaves FAULT and returns to ACQUIRE.
- locked  output  1: monitor is tracking a legal rotation.
- phase  output  3: last legally decoded phase, 0..7 (0 = N-G, 7 = W-Y).
- err  output  1: sticky violation flag.
- err_code  output  3: cause of the violation, captured on entry to FAULT.
- rotations  output  ROT_W: count of completed W-Y to N-G transitions.

## Operation

- Decode, combinational, per sample:
  - Exactly one direction non-RED, showing GREEN or YELLOW, others RED: legal, phase = 2*dir + (YELLOW?1:0), dir order N=0, E=1, S=2, W=3.
  - Two or more directions showing GREEN/YELLOW: CONFLICT.
  - Any lamp code not one-hot, or all four RED: ENCODING.
- err_code values:
  - NONE=0
  - CONFLICT=1
  - ENCODING=2
  - SEQ=3 (wrong legal phase)
  - DWELL_SHORT=4 (next phase arrived before DWELL cycles)
  - DWELL_LONG=5 (current phase held beyond DWELL cycles)
- Priority when several apply: CONFLICT > ENCODING > SEQ > DWELL_SHORT > DWELL_LONG.
- ACQUIRE state:
  - locked=0, no errors raised.
  - The first legal sample of phase 0 moves to TRACK with dwell_cnt=1 and phase=0.
  - All other samples are ignored.
- TRACK state (locked=1):
  - Sample == current phase and dwell_cnt<DWELL: dwell_cnt++.
  - Sample == current phase and dwell_cnt==DWELL: DWELL_LONG.
  - Sample == (phase+1) mod 8 and dwell_cnt==DWELL: advance phase, dwell_cnt=1. Going 7 to 0 also increments rotations, which wraps modulo 2^ROT_W.
  - Sample == next phase and dwell_cnt<DWELL: DWELL_SHORT.
  - Any other legal phase: SEQ. Illegal sample: CONFLICT or ENCODING.
  - Any violation moves to FAULT.
- FAULT state:
  - err=1, locked=0; err_code and phase frozen at their values from the violation cycle.
  - Further violations do not overwrite err_code.
  - clr_err returns to ACQUIRE, clears err, sets err_code=NONE. rotations is preserved.
- clr_err outside FAULT has no effect.
- If clr_err coincides with a violating sample while in FAULT, clr_err wins and the next state is ACQUIRE.
- rst_n low dominates every other input.

## Timing

- All outputs registered. A sample taken at edge k is reflected on outputs after edge k (latency 1 cycle).
- Reset (rst_n low at an edge) sets: state=ACQUIRE, locked=0, phase=0, err=0, err_code=0, rotations=0, dwell_cnt=0.
- Reset mid-rotation or mid-fault discards all tracking; re-acquisition requires a new phase 0 sample.
- With DWELL=1 and a conforming controller released from reset at phase 0: locked=1 one cycle after the first sampled N-G. rotations increments once every 8 cycles thereafter.
- err rises exactly one cycle after the violating sample and never glitches combinationally.

## Structure

- Shared package traffic_pkg holds:
  - Lamp constants RED/YELLOW/GREEN.
  - phase_t enum, 8 values.
  - err_code_t enum.
  - Monitor state enum {ACQUIRE, TRACK, FAULT}.
- The controller is also to import the lamp constants from traffic_pkg.
- One combinational sub-module, light_pattern_decoder: four lamp codes in; legal, phase, conflict and encoding_err out.
- FSM, dwell counter and rotation counter live in the top module.

## Test plan

- Conforming sequence, DWELL=1, 20 cycles from reset: locked=1 from cycle 1, phase cycles 0..7, rotations=2 after the second W-Y to N-G transition, err=0.
- North=GREEN and East=GREEN in the same sample while in TRACK: err=1 next cycle, err_code=1, locked=0; phase holds its prior value.
- West=011 during the W-Y slot: err_code=2. Then pulse clr_err: err=0, state ACQUIRE, re-locks on the next N-G.
- Skip from phase 2 directly to phase 4: err_code=3.
- DWELL=3: hold N-G for 2 cycles then N-Y gives err_code=4. Hold N-G for 4 cycles gives err_code=5. Exactly 3 cycles keeps locked=1.
- Assert rst_n low for one cycle in FAULT (err_code=1) while clr_err is also high: all outputs read their reset values, including rotations=0.
